// File: rtl/reg64_bank_ctrl.sv
// Bank of 64-bit control registers shared between a 32-bit Avalon-MM host and one fabric writer.
// Host 64-bit accesses are made atomic via a low-half write stage and a high-half read snapshot.
module reg64_bank_ctrl #(
    parameter int unsigned NUM_REGS = 4,
    parameter logic [63:0] RST_VAL  = 64'h0,
    parameter int unsigned AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) + 1 : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [AW-1:0]            i_avs_address,
    input  logic                     i_avs_write,
    input  logic [31:0]              i_avs_writedata,
    input  logic                     i_avs_read,
    output logic [31:0]              o_avs_readdata,
    output logic                     o_avs_readdatavalid,
    output logic                     o_avs_waitrequest,
    input  logic                     i_fab_req,
    input  logic [3:0]               i_fab_idx,
    input  logic [63:0]              i_fab_data,
    output logic                     o_fab_ack,
    output logic [64*NUM_REGS-1:0]   o_regs,
    output logic [NUM_REGS-1:0]      o_upd_pulse
);

    localparam int unsigned IW = 5;

    typedef enum logic {
        PRIO_HOST = 1'b0,
        PRIO_FAB  = 1'b1
    } prio_e;

    logic [63:0]         regs_q [NUM_REGS];
    logic [31:0]         lo_stage_q;
    logic [31:0]         hi_snap_q;
    logic [IW-1:0]       snap_idx_q;
    logic                snap_valid_q;
    prio_e               prio_q;
    prio_e               prio_d;
    logic [31:0]         rdata_q;
    logic                rvalid_q;
    logic                fab_ack_q;
    logic [NUM_REGS-1:0] upd_q;
    logic [NUM_REGS-1:0] upd_d;

    logic [IW-1:0] host_idx;
    logic [IW-1:0] fab_idx;
    logic          host_in_range;
    logic          fab_in_range;
    logic          host_lo_write;
    logic          host_req;
    logic          fab_elig;
    logic          contended;
    logic          host_grant;
    logic          fab_grant;
    logic          rd_accept;
    logic          snap_hit;
    logic [63:0]   live_reg;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [63:0]   wr_data;

    // Address bit 0 selects the half; the remaining bits name the register.
    assign host_idx      = IW'(i_avs_address >> 1);
    assign fab_idx       = {1'b0, i_fab_idx};
    assign host_in_range = host_idx < IW'(NUM_REGS);
    assign fab_in_range  = fab_idx < IW'(NUM_REGS);

    assign host_lo_write = i_avs_write & ~i_avs_address[0];
    // An out-of-range commit never competes for the port, so it never stalls.
    assign host_req      = i_avs_write & i_avs_address[0] & host_in_range;
    assign fab_elig      = i_fab_req & ~fab_ack_q;
    assign contended     = host_req & fab_elig;
    assign host_grant    = host_req & (~fab_elig | (prio_q == PRIO_HOST));
    assign fab_grant     = fab_elig & (~host_req | (prio_q == PRIO_FAB));

    assign o_avs_waitrequest = host_req & ~host_grant;

    assign rd_accept = i_avs_read & ~i_avs_write;
    assign snap_hit  = snap_valid_q & (snap_idx_q == host_idx);

    // Out-of-range fabric writes are granted and acked but never reach the bank.
    assign wr_en   = host_grant | (fab_grant & fab_in_range);
    assign wr_idx  = host_grant ? host_idx : fab_idx;
    assign wr_data = host_grant ? {i_avs_writedata, lo_stage_q} : i_fab_data;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        live_reg = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (host_idx == IW'(i)) begin
                live_reg = regs_q[i];
            end
        end
    end

    always_comb begin
        upd_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            upd_d[i] = wr_en & (wr_idx == IW'(i));
        end
    end

    // The loser of a contended grant gets priority next time.
    always_comb begin
        prio_d = prio_q;
        if (contended) begin
            prio_d = host_grant ? PRIO_FAB : PRIO_HOST;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the register bank itself is reset because the datapath consumes it directly.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
            lo_stage_q   <= '0;
            hi_snap_q    <= '0;
            snap_idx_q   <= '0;
            snap_valid_q <= 1'b0;
            prio_q       <= PRIO_HOST;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            fab_ack_q    <= 1'b0;
            upd_q        <= '0;
        end else begin
            if (host_lo_write) begin
                lo_stage_q <= i_avs_writedata;
            end

            rvalid_q <= rd_accept;
            if (rd_accept) begin
                if (!i_avs_address[0]) begin
                    rdata_q      <= live_reg[31:0];
                    hi_snap_q    <= live_reg[63:32];
                    snap_idx_q   <= host_idx;
                    snap_valid_q <= 1'b1;
                end else if (snap_hit) begin
                    rdata_q      <= hi_snap_q;
                    snap_valid_q <= 1'b0;
                end else begin
                    rdata_q <= live_reg[63:32];
                end
            end

            prio_q    <= prio_d;
            fab_ack_q <= fab_grant;
            upd_q     <= upd_d;

            for (int i = 0; i < NUM_REGS; i++) begin
                if (upd_d[i]) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        o_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_regs[64*i +: 64] = regs_q[i];
        end
    end

    assign o_avs_readdata      = rdata_q;
    assign o_avs_readdatavalid = rvalid_q;
    assign o_fab_ack           = fab_ack_q;
    assign o_upd_pulse         = upd_q;

endmodule

// File: doc/reg64_bank_ctrl.md
# reg64_bank_ctrl

Controller for a bank of NUM_REGS 64-bit control registers shared between the HPS (32-bit Avalon-MM slave on the lightweight bridge) and one fabric-side writer. It makes 64-bit host writes and reads atomic over a 32-bit bus by staging the low half and snapshotting the high half. It arbitrates round-robin for the single bank write port between host commits and fabric updates, and publishes all register values plus per-register update strobes to the datapath.

## Interface
- NUM_REGS, 4: number of 64-bit registers, 1..16.
- RST_VAL, 64'h0: reset value of every register.
- AW, $clog2(NUM_REGS)+1 (minimum 1 when NUM_REGS = 1): Avalon word-address width. Bit 0 selects the half (0 = low, 1 = high); the upper bits select the register index.
- i_clk  in  1  single clock. Everything is in this domain.
- i_rst  in  1  synchronous, active-high reset.
- i_avs_address  in  AW  word address.
- i_avs_write  in  1  host write strobe.
- i_avs_writedata  in  32  host write data.
- i_avs_read  in  1  host read strobe.
- o_avs_readdata  out  32  read data, valid with o_avs_readdatavalid.
- o_avs_readdatavalid  out  1  one-cycle read response.
- o_avs_waitrequest  out  1  stalls a host high-half write that lost arbitration. Combinational.
- i_fab_req  in  1  fabric write request; held until acked.
- i_fab_idx  in  4  fabric target register index.
- i_fab_data  in  64  fabric write data; held with the request.
- o_fab_ack  out  1  one-cycle pulse the cycle after the fabric write is performed.
- o_regs  out  64*NUM_REGS  register contents, flattened. Register i is at [64*i+63:64*i].
- o_upd_pulse  out  NUM_REGS  one-cycle strobe per register, high in the first cycle o_regs shows a new written value.

## Operation
- Host low-half write: loads lo_stage (32 bits). The register bank is unchanged. The write is never stalled.
- Host high-half write ("commit"): requests the bank write port with data {writedata, lo_stage} and target idx. lo_stage is retained after the commit; it is not cleared.
- Host low-half read: returns reg[idx][31:0]. In the same cycle it captures reg[idx][63:32] into hi_snap, sets snap_idx = idx and sets snap_valid.
- Host high-half read: if snap_valid and snap_idx == idx, returns hi_snap and clears snap_valid. Otherwise returns live reg[idx][63:32].
- Read and write asserted in the same cycle: the write is performed and the read is dropped (no readdatavalid).
- Arbitration: one bank write per cycle. Requesters are the host commit and the fabric request.
  - A fabric request is ineligible while o_fab_ack = 1. This is the dead cycle that lets the fabric drop i_fab_req.
  - With a single eligible requester, that requester is granted.
  - With both eligible, the one named by prio is granted; the loser stalls. The host stalls via o_avs_waitrequest = 1. The fabric stalls by receiving no ack.
  - After a contended grant, prio points at the loser. Uncontended grants leave prio unchanged.
  - Reset value of prio = HOST.
- Out-of-range index (idx >= NUM_REGS):
  - Host commit: completes without stall and without a bank write.
  - Fabric request: acked with no bank write.
  - Reads: return 32'h0.
  - No o_upd_pulse is generated in any of these cases.
- Reset: registers = RST_VAL, lo_stage = 0, hi_snap = 0, snap_valid = 0, prio = HOST.

## Timing
- All outputs are registered except o_avs_waitrequest, which is a combinational function of i_avs_write, i_avs_address[0], the fabric request, o_fab_ack and prio.
- Reset values: o_avs_readdata = 0, o_avs_readdatavalid = 0, o_fab_ack = 0, o_upd_pulse = 0, o_regs = RST_VAL replicated. o_avs_waitrequest = 0 whenever no host commit is pending.
- Read latency: o_avs_readdatavalid and o_avs_readdata appear 1 cycle after the accepted read (edge k+1).
- Write latency: a grant at edge k makes o_regs updated and o_upd_pulse[idx] = 1 during cycle k+1. A fabric grant also raises o_fab_ack in cycle k+1.
- A read in the same cycle as a bank write to the same register returns the old value.
- Back-to-back fabric writes are possible every 2 cycles. Back-to-back host commits are possible every cycle.
- i_rst asserted mid-transaction:
  - Pending grants, acks and read responses are discarded.
  - Outputs take their reset values at the next edge.
  - No o_upd_pulse is generated for the aborted write.

## Test plan
- Reset, then read all halves -> readdata = RST_VAL halves, readdatavalid 1 cycle after each read, o_upd_pulse = 0.
- Write low 0x89ABCDEF, then high 0x01234567, to reg 1 -> o_regs[127:64] = 64'h0123456789ABCDEF in the cycle after the commit, o_upd_pulse = 4'b0010 for 1 cycle. No change to o_regs between the two writes.
- Read low of reg 2, fabric writes reg 2 = 64'hFFFF_FFFF_0000_0000, then read high of reg 2 -> high read returns the pre-update high half (snapshot). A second high read returns 0xFFFFFFFF.
- Host commit to reg 0 and fabric request to reg 3 in the same cycle from reset:
  - Host is granted and waitrequest = 0.
  - Fabric is granted next cycle and acked the cycle after.
  - Repeat the collision with prio = FAB: host sees waitrequest = 1 for exactly 1 cycle.
- Fabric holds i_fab_req for 3 consecutive writes -> acks are 2 cycles apart. Exactly one o_upd_pulse per write.
- Fabric idx = 5 with NUM_REGS = 4 -> ack asserted, o_regs unchanged, no o_upd_pulse. Assert i_rst during a pending host stall -> waitrequest = 0 and o_regs = RST_VAL next cycle.
